adder_arbiter: RTL and testbench

Time-multiplexes one shared combinational 16-bit adder (sum plus carry-out) among NUM_REQ requesters, such as oscillator phase accumulators and envelope steppers. It sits between the requesters and the adder instance. Each requester hands over one operand set with a valid/ready handshake. The block grants requesters in round-robin order, drives the adder, holds the operands for a programmable settle time, registers the 17-bit result, and returns it on a shared response bus tagged with the requester ID.

---
 rtl/adder_arbiter_pkg.sv | 19 +
 rtl/adder_arbiter_if.sv | 47 ++++
 rtl/adder_arbiter_rr_pick.sv | 32 +++
 rtl/adder_arbiter.sv | 132 +++++++++++++
 tb/tb_adder_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the adder arbiter: FSM state encoding,
// default operand width and the requester-ID width function.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      RESP
   } state_e;

   localparam int DEFAULT_WIDTH = 16;
   localparam int CNT_W         = 4;

   function automatic int id_width(input int n);
      id_width = 1;
      while ((1 << id_width) < n) id_width++;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of requester, response and shared-adder signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface adder_arbiter_if
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int ID_W    = id_width(NUM_REQ)
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_cin;

   logic [WIDTH-1:0]         add_a;
   logic [WIDTH-1:0]         add_b;
   logic                     add_cin;
   logic [WIDTH-1:0]         add_sum;
   logic                     add_cout;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_cout;

   modport slave (
      input  req_valid, req_a, req_b, req_cin,
      output req_ready,
      output add_a, add_b, add_cin,
      input  add_sum, add_cout,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_a, req_b, req_cin,
      input  req_ready,
      input  add_a, add_b, add_cin,
      output add_sum, add_cout,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
      output rsp_ready
   );

endinterface

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant,
// wrapping modulo NUM_REQ, wins.
module rr_pick
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      int cand;
      cand = 0;
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_grant) + k) % NUM_REQ;
         if (!any && (((req >> cand) & NUM_REQ'(1)) != '0)) begin
            any = 1'b1;
            gnt = NUM_REQ'(1) << cand;
            idx = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Time-multiplexes one external combinational adder among NUM_REQ requesters:
// round-robin grant, registered operands held for SETTLE_CYCLES, tagged response.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SETTLE_CYCLES = 1,
   parameter int ID_W          = id_width(NUM_REQ)
) (
   input logic            clk,
   input logic            reset,
   adder_arbiter_if.slave bus
);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               op_cin_q, op_cin_d;
   logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
   logic               rsp_cout_q, rsp_cout_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               accept;
   logic               settle_done;

   logic [WIDTH-1:0]   req_a_arr [NUM_REQ];
   logic [WIDTH-1:0]   req_b_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
      assign req_b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W)
   ) u_pick (
      .req        (bus.req_valid),
      .last_grant (last_grant_q),
      .gnt        (pick_gnt),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   assign accept      = (state_q == IDLE) && pick_any;
   assign settle_done = (state_q == ADD) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_any)      state_d = ADD;
         ADD:     if (settle_done)   state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = 1'b0;
      if (state_q == IDLE) bus.req_ready = pick_gnt;
      if (state_q == RESP) bus.rsp_valid = 1'b1;
   end

   // Adder inputs come only from registers so requester-side changes never reach it.
   assign bus.add_a    = op_a_q;
   assign bus.add_b    = op_b_q;
   assign bus.add_cin  = op_cin_q;
   assign bus.rsp_id   = rsp_id_q;
   assign bus.rsp_sum  = rsp_sum_q;
   assign bus.rsp_cout = rsp_cout_q;

   always_comb begin
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      cnt_d        = cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_cin_d     = op_cin_q;
      rsp_sum_d    = rsp_sum_q;
      rsp_cout_d   = rsp_cout_q;
      if (accept) begin
         last_grant_d = pick_idx;
         rsp_id_d     = pick_idx;
         cnt_d        = '0;
         op_a_d       = req_a_arr[pick_idx];
         op_b_d       = req_b_arr[pick_idx];
         op_cin_d     = bus.req_cin[pick_idx];
      end else if (state_q == ADD) begin
         cnt_d = cnt_q + 1'b1;
         if (settle_done) begin
            rsp_sum_d  = bus.add_sum;
            rsp_cout_d = bus.add_cout;
            cnt_d      = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= ID_W'(NUM_REQ - 1);
         rsp_id_q     <= '0;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_cin_q     <= 1'b0;
         rsp_sum_q    <= '0;
         rsp_cout_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_cin_q     <= op_cin_d;
         rsp_sum_q    <= rsp_sum_d;
         rsp_cout_q   <= rsp_cout_d;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: scoreboard of per-requester expected sums, a
// grant/latency monitor, random soak, plus directed reset tests on a SETTLE=4 copy.
module tb_adder_arbiter;
   import adder_arb_pkg::*;

   localparam int NR = 4;
   localparam int W  = 16;
   localparam int IW = 2;
   localparam int S1 = 1;
   localparam int S4 = 4;

   logic clk = 1'b0;
   logic rst1, rst4;
   logic rr1, rr4;
   logic         v1 [NR];
   logic [W-1:0] a1 [NR];
   logic [W-1:0] b1 [NR];
   logic         c1 [NR];
   logic         v4 [NR];
   logic [W-1:0] a4 [NR];
   logic [W-1:0] b4 [NR];
   logic         c4 [NR];

   int n_chk = 0;
   int n_fail = 0;
   int n_iss = 0;
   int n_rsp = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   bit soak_on = 1'b0;

   logic [W:0] exp_q [NR][$];
   int         grant_log [$];
   bit         busy = 1'b0;
   bit         in_resp = 1'b0;
   int         last_g = NR - 1;
   int         owner = 0;
   int         grant_cyc = 0;
   logic [IW+W:0] held;
   logic [NR-1:0] exp_rdy;
   int            g_pick;
   logic [W:0]    e_val;

   adder_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus1 ();
   adder_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus4 ();

   adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .SETTLE_CYCLES(S1)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1)
   );

   adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .SETTLE_CYCLES(S4)) dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4)
   );

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign bus1.req_valid[g]       = v1[g];
      assign bus1.req_a[g*W +: W]    = a1[g];
      assign bus1.req_b[g*W +: W]    = b1[g];
      assign bus1.req_cin[g]         = c1[g];
      assign bus4.req_valid[g]       = v4[g];
      assign bus4.req_a[g*W +: W]    = a4[g];
      assign bus4.req_b[g*W +: W]    = b4[g];
      assign bus4.req_cin[g]         = c4[g];
   end

   // Shared 16-bit adders sitting outside each arbiter.
   assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + (W+1)'(bus1.add_cin);
   assign {bus4.add_cout, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + (W+1)'(bus4.add_cin);
   assign bus1.rsp_ready = rr1;
   assign bus4.rsp_ready = rr4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=900000", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Round-robin rule: first valid requester after the previous grant, wrapping.
   function automatic int rr_next(input logic [NR-1:0] vld, input int last);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (vld[IW'(c)]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst1) begin
         exp_rdy = '0;
         g_pick  = -1;
         if (!busy) g_pick = rr_next(bus1.req_valid, last_g);
         if (g_pick >= 0) exp_rdy = NR'(1) << g_pick;
         chk("req_ready", 32'(bus1.req_ready), 32'(exp_rdy));
         if (g_pick >= 0) begin
            busy      = 1'b1;
            last_g    = g_pick;
            owner     = g_pick;
            grant_cyc = cyc;
            grant_log.push_back(g_pick);
         end
         if (!in_resp)
            chk("rsp_valid_timing", 32'(bus1.rsp_valid), 32'(busy && (cyc == grant_cyc + 1 + S1)));
         else
            chk("rsp_valid_held", 32'(bus1.rsp_valid), 32'd1);
         if (bus1.rsp_valid) begin
            if (!in_resp) begin
               in_resp = 1'b1;
               chk("rsp_id", 32'(bus1.rsp_id), 32'(owner));
               chk("rsp_pending", 32'(exp_q[bus1.rsp_id].size() != 0), 32'd1);
               if (exp_q[bus1.rsp_id].size() != 0) begin
                  e_val = exp_q[bus1.rsp_id].pop_front();
                  chk("rsp_result", 32'({bus1.rsp_cout, bus1.rsp_sum}), 32'(e_val));
               end
               held = {bus1.rsp_id, bus1.rsp_cout, bus1.rsp_sum};
            end else begin
               chk("rsp_stable", 32'({bus1.rsp_id, bus1.rsp_cout, bus1.rsp_sum}), 32'(held));
            end
            if (rr1) begin
               in_resp = 1'b0;
               busy    = 1'b0;
               n_rsp++;
            end
         end
      end
   end

   task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] e);
      int t;
      @(posedge clk); #1;
      v1[i] = 1'b1; a1[i] = a; b1[i] = b; c1[i] = c;
      exp_q[i].push_back(e);
      n_iss++;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus1.req_ready[IW'(i)] && t < 300);
      chk("req_accept", 32'(bus1.req_ready[IW'(i)]), 32'd1);
      @(posedge clk); #1;
      v1[i] = 1'b0;
   endtask

   task automatic drive_many(input int i, input int n, input bit rnd);
      logic [W-1:0] a, b;
      logic c;
      for (int k = 0; k < n; k++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
         end else begin
            a = W'(16'h1000 * i + k);
            b = W'(16'h0101 * (k + 1));
            c = 1'(k);
         end
         drive(i, a, b, c, {1'b0, a} + {1'b0, b} + (W+1)'(c));
      end
   endtask

   initial begin
      int t;
      bit found;
      for (int i = 0; i < NR; i++) begin
         v1[i] = 0; a1[i] = '0; b1[i] = '0; c1[i] = 0;
         v4[i] = 0; a4[i] = '0; b4[i] = '0; c4[i] = 0;
      end
      rr1 = 1'b1; rr4 = 1'b1;
      rst1 = 1'b1; rst4 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus1.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(bus1.rsp_id),    32'd0);
      chk("rst_rsp_res",   32'({bus1.rsp_cout, bus1.rsp_sum}), 32'd0);
      chk("rst_add_ops",   32'({bus1.add_cin, bus1.add_a, bus1.add_b}), 32'd0);
      @(posedge clk); #1;
      rst1 = 1'b0; rst4 = 1'b0;
      mon_en = 1'b1;

      // Fairness: everyone requests continuously.
      fork
         drive_many(0, 3, 1'b0);
         drive_many(1, 3, 1'b0);
         drive_many(2, 3, 1'b0);
         drive_many(3, 3, 1'b0);
      join
      repeat (4) @(posedge clk);
      chk("fair_count", 32'(grant_log.size()), 32'd12);
      for (int k = 0; k < 12 && k < grant_log.size(); k++)
         chk("fair_order", 32'(grant_log[k]), 32'(k % NR));

      // Directed arithmetic cases.
      drive(0, 16'h1234, 16'h0FFF, 1'b1, 17'h02234);
      drive(1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      drive(3, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      repeat (4) @(posedge clk);

      // Backpressure: response held while requester 2 waits.
      #1 rr1 = 1'b0;
      fork
         drive(1, 16'hA5A5, 16'h0F0F, 1'b1, 17'h0B4B5);
         begin
            repeat (2) @(posedge clk);
            drive(2, 16'h8000, 16'h8000, 1'b0, 17'h10000);
         end
         begin
            t = 0;
            while (!bus1.rsp_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            repeat (5) @(posedge clk);
            #1 rr1 = 1'b1;
         end
      join
      repeat (6) @(posedge clk);

      // Random soak with random response backpressure.
      soak_on = 1'b1;
      fork
         begin
            while (soak_on) begin
               @(posedge clk); #1;
               rr1 = ($urandom_range(0, 9) < 7);
            end
         end
      join_none
      fork
         drive_many(0, 600, 1'b1);
         drive_many(1, 600, 1'b1);
         drive_many(2, 600, 1'b1);
         drive_many(3, 600, 1'b1);
      join
      soak_on = 1'b0;
      @(posedge clk); #2;
      rr1 = 1'b1;
      repeat (20) @(posedge clk);
      for (int i = 0; i < NR; i++) chk("queue_drained", 32'(exp_q[i].size()), 32'd0);
      chk("rsp_count", 32'(n_rsp), 32'(n_iss));

      // SETTLE_CYCLES=4 copy: latency, then reset in the middle of ADD.
      @(posedge clk); #1;
      v4[1] = 1'b1; a4[1] = 16'h00FF; b4[1] = 16'h0001; c4[1] = 1'b0;
      @(negedge clk);
      chk("s4_grant1", 32'(bus4.req_ready), 32'h2);
      @(posedge clk); #1;
      v4[1] = 1'b0;
      t = 1; found = 1'b0;
      while (t < 20 && !found) begin
         @(negedge clk);
         if (bus4.rsp_valid) found = 1'b1;
         else t++;
      end
      chk("s4_latency", 32'(t), 32'(1 + S4));
      chk("s4_result", 32'({bus4.rsp_cout, bus4.rsp_sum}), 32'h00100);
      chk("s4_rsp_id", 32'(bus4.rsp_id), 32'd1);
      @(posedge clk); #1;
      v4[0] = 1'b1; a4[0] = 16'h1234; b4[0] = 16'h4321; c4[0] = 1'b1;
      @(negedge clk);
      chk("s4_grant0", 32'(bus4.req_ready), 32'h1);
      @(posedge clk); #1;
      v4[0] = 1'b0;
      @(posedge clk); #1;
      rst4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_req_ready", 32'(bus4.req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(bus4.rsp_valid), 32'd0);
      chk("midrst_rsp_id",    32'(bus4.rsp_id),    32'd0);
      chk("midrst_rsp_res",   32'({bus4.rsp_cout, bus4.rsp_sum}), 32'd0);
      chk("midrst_add_ops",   32'({bus4.add_cin, bus4.add_a, bus4.add_b}), 32'd0);
      @(posedge clk); #1;
      rst4 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("midrst_no_rsp", 32'(bus4.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      v4[0] = 1'b1; v4[1] = 1'b1;
      @(negedge clk);
      chk("midrst_first_grant", 32'(bus4.req_ready), 32'h1);
      @(posedge clk); #1;
      v4[0] = 1'b0; v4[1] = 1'b0;
      repeat (8) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
